sram_like_arbiter: RTL



---
 rtl/sram_like_pkg.sv | 9 +
 rtl/sram_like_prio_sel.sv | 13 +
 rtl/sram_like_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared state, size and grant encodings for the sram-like arbiter
package sram_like_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;
endpackage

// File: rtl/sram_like_prio_sel.sv
// sram_like_prio_sel: data-first priority with a starvation escape for the instruction port
module sram_like_prio_sel
  import sram_like_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       inst_req,
  input  logic       data_req,
  input  logic [3:0] starve_cnt,
  output logic       grant
);
  assign grant = (data_req && !(inst_req && starve_cnt == 4'(STARVE_LIMIT))) ? GRANT_DATA : GRANT_INST;
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: 2:1 arbiter merging instruction and data sram-like ports onto one master port,
// one transaction in flight, data-first with bounded instruction starvation
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);
  arb_state_t state, next;
  logic grant, sel, any_req, in_addr, in_data;
  logic [3:0] starve_cnt;
  assign any_req = inst_req | data_req;
  assign in_addr = state == ADDR;
  assign in_data = state == DATA;
  sram_like_prio_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio_sel (
    .inst_req  (inst_req),
    .data_req  (data_req),
    .starve_cnt(starve_cnt),
    .grant     (sel)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= GRANT_INST;
      starve_cnt <= '0;
    end else begin
      state <= next;
      if (state == IDLE && any_req) begin
        grant      <= sel;
        // counts data grants that passed over a waiting instruction request
        starve_cnt <= (sel == GRANT_DATA && inst_req)
                      ? ((starve_cnt == 4'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 4'd1)
                      : 4'd0;
      end
    end
  end
  always_comb begin
    next = state;
    next = (state == IDLE) ? (any_req ? ADDR : IDLE) :
           (state == ADDR) ? (m_addr_ok ? DATA : ADDR) :
                             (m_data_ok ? IDLE : DATA);
  end
  // request fields are only driven while a request is presented, zero otherwise
  assign m_req   = in_addr;
  assign m_wr    = in_addr & (grant ? data_wr : inst_wr);
  assign m_size  = in_addr ? (grant ? data_size : inst_size) : '0;
  assign m_addr  = in_addr ? (grant ? data_addr : inst_addr) : '0;
  assign m_wdata = in_addr ? (grant ? data_wdata : inst_wdata) : '0;
  assign inst_addr_ok = in_addr & (grant == GRANT_INST) & m_addr_ok;
  assign data_addr_ok = in_addr & (grant == GRANT_DATA) & m_addr_ok;
  assign inst_data_ok = in_data & (grant == GRANT_INST) & m_data_ok;
  assign data_data_ok = in_data & (grant == GRANT_DATA) & m_data_ok;
  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;
endmodule
